// File: rtl/pong_game_ctrl.sv
// Pong game controller: sequences serve, play, pause, miss and game-over
// phases, keeps a two-digit BCD score and the remaining lives, and drives
// the ball enable / ball reset controls for the motion logic.
module pong_game_ctrl #(
    parameter int LIVES        = 3,
    parameter int SERVE_FRAMES = 60,
    parameter int OVER_FRAMES  = 180
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       frame_tick,
    input  logic       hit,
    input  logic       miss,
    output logic       ball_enable,
    output logic       ball_reset,
    output logic [7:0] score,
    output logic [1:0] lives,
    output logic       game_over,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_PAUSE = 3'd3,
        ST_MISS  = 3'd4,
        ST_OVER  = 3'd5
    } state_t;

    localparam logic [7:0] SERVE_LOAD = 8'(SERVE_FRAMES - 1);
    localparam logic [7:0] OVER_LOAD  = 8'(OVER_FRAMES - 1);
    localparam logic [1:0] LIVES_LOAD = 2'(LIVES);

    // BCD increment of a two-digit score, saturating at 99
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        logic [7:0] r;
        if (v == 8'h99) begin
            r = v;
        end else if (v[3:0] == 4'd9) begin
            r = {v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

    state_t     state_r, state_s;
    logic [7:0] score_r, score_s;
    logic [1:0] lives_r, lives_s;
    logic [7:0] timer_r, timer_s;
    logic       ball_enable_r, ball_reset_r, game_over_r;
    logic       start_q_r, hit_q_r, miss_q_r;
    // start must be seen low once after reset before it can produce an event
    logic       start_armed_r;
    logic       start_ev_s, hit_ev_s, miss_ev_s, expired_s;

    assign start_ev_s = start & ~start_q_r & start_armed_r;
    assign hit_ev_s   = hit & ~hit_q_r;
    assign miss_ev_s  = miss & ~miss_q_r;
    assign expired_s  = frame_tick & (timer_r == 8'd0);

    // Next-state, score, lives and timer decisions
    always_comb begin
        state_s = state_r;
        score_s = score_r;
        lives_s = lives_r;
        timer_s = timer_r;
        case (state_r)
            ST_IDLE: begin
                if (start_ev_s) begin
                    state_s = ST_SERVE;
                    score_s = 8'h00;
                    lives_s = LIVES_LOAD;
                    timer_s = SERVE_LOAD;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SERVE: begin
                if (expired_s) begin
                    state_s = ST_PLAY;
                end else if (frame_tick) begin
                    timer_s = timer_r - 8'd1;
                end else begin
                    state_s = ST_SERVE;
                end
            end
            ST_PLAY: begin
                if (miss_ev_s) begin
                    lives_s = lives_r - 2'd1;
                    if (lives_r == 2'd1) begin
                        state_s = ST_OVER;
                        timer_s = OVER_LOAD;
                    end else begin
                        state_s = ST_MISS;
                        timer_s = SERVE_LOAD;
                    end
                end else begin
                    if (hit_ev_s) begin
                        score_s = bcd_inc(score_r);
                    end else begin
                        score_s = score_r;
                    end
                    if (start_ev_s) begin
                        state_s = ST_PAUSE;
                    end else begin
                        state_s = ST_PLAY;
                    end
                end
            end
            ST_PAUSE: begin
                if (start_ev_s) begin
                    state_s = ST_PLAY;
                end else begin
                    state_s = ST_PAUSE;
                end
            end
            ST_MISS: begin
                if (expired_s) begin
                    state_s = ST_SERVE;
                    timer_s = SERVE_LOAD;
                end else if (frame_tick) begin
                    timer_s = timer_r - 8'd1;
                end else begin
                    state_s = ST_MISS;
                end
            end
            ST_OVER: begin
                if (expired_s) begin
                    state_s = ST_IDLE;
                end else if (frame_tick) begin
                    timer_s = timer_r - 8'd1;
                end else begin
                    state_s = ST_OVER;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, counters, registered outputs and input edge registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r       <= ST_IDLE;
            score_r       <= 8'h00;
            lives_r       <= 2'd0;
            timer_r       <= 8'd0;
            ball_enable_r <= 1'b0;
            ball_reset_r  <= 1'b0;
            game_over_r   <= 1'b0;
            start_q_r     <= 1'b0;
            hit_q_r       <= 1'b0;
            miss_q_r      <= 1'b0;
            start_armed_r <= 1'b0;
        end else begin
            state_r       <= state_s;
            score_r       <= score_s;
            lives_r       <= lives_s;
            timer_r       <= timer_s;
            ball_enable_r <= (state_s == ST_PLAY);
            ball_reset_r  <= (state_s == ST_SERVE) && (state_r != ST_SERVE);
            game_over_r   <= (state_s == ST_OVER);
            start_q_r     <= start;
            hit_q_r       <= hit;
            miss_q_r      <= miss;
            start_armed_r <= start_armed_r | ~start;
        end
    end

    assign state       = state_r;
    assign score       = score_r;
    assign lives       = lives_r;
    assign ball_enable = ball_enable_r;
    assign ball_reset  = ball_reset_r;
    assign game_over   = game_over_r;

endmodule

// File: doc/pong_game_ctrl.md
PONG_GAME_CTRL -- requirements
Module: pong_game_ctrl

Interface
REQ-001 Parameter LIVES, default 3, lives loaded at game start; legal range 1..3.
REQ-002 Parameter SERVE_FRAMES, default 60, frame ticks spent in SERVE and in MISS; legal range 1..256.
REQ-003 Parameter OVER_FRAMES, default 180, frame ticks spent in OVER; legal range 1..256.
REQ-004 clk  input  1  single system clock; all state changes on its rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  start/pause button, level, synchronous to clk.
REQ-007 frame_tick  input  1  one-clock pulse once per video frame (start of vertical retrace).
REQ-008 hit  input  1  level, high while the ball overlaps the paddle.
REQ-009 miss  input  1  level, high while the ball is past the right table edge.
REQ-010 ball_enable  output  1  high only in PLAY; gates ball and paddle motion updates.
REQ-011 ball_reset  output  1  one-clock pulse; returns the ball to its serve position.
REQ-012 score  output  8  two-digit BCD score, [7:4] tens, [3:0] units.
REQ-013 lives  output  2  remaining lives, binary.
REQ-014 game_over  output  1  high only in OVER.
REQ-015 state  output  3  current state code, for debug and display.

Function
REQ-016 States and codes SHALL be: IDLE=0, SERVE=1, PLAY=2, PAUSE=3, MISS=4, OVER=5; codes 6-7 SHALL return to IDLE on the next clock.
REQ-017 start, hit and miss SHALL each be registered once; an event is the rising edge (x & ~x_q); level-high inputs SHALL count only once.
REQ-018 An internal 8-bit timer SHALL decrement by 1 on each frame_tick in SERVE, MISS and OVER; "expiry" is a frame_tick arriving while timer==0.
REQ-019 IDLE: on start event go to SERVE, clear score to 0x00, load lives=LIVES and timer=SERVE_FRAMES-1.
REQ-020 SERVE: on expiry go to PLAY; start, hit and miss events are ignored.
REQ-021 PLAY: a hit event SHALL increment score in BCD (0x09->0x10, 0x99 saturates at 0x99).
REQ-022 PLAY: a miss event SHALL decrement lives; if lives was 1 go to OVER with timer=OVER_FRAMES-1, otherwise go to MISS with timer=SERVE_FRAMES-1.
REQ-023 PLAY: hit and miss events in the same clock -- miss wins, score unchanged.
REQ-024 PLAY: a start event with no miss event goes to PAUSE; a miss event in the same clock takes priority over start.
REQ-025 PAUSE: hit and miss events are ignored; a start event returns to PLAY; timer, score and lives are held.
REQ-026 MISS: on expiry go to SERVE with timer=SERVE_FRAMES-1.
REQ-027 OVER: score and lives are held for display; start events are ignored; on expiry go to IDLE.
REQ-028 ball_reset SHALL be high exactly during the first clock in which state==SERVE, on every entry to SERVE.
REQ-029 All outputs SHALL be registered.
REQ-030 ball_enable and game_over SHALL change in the same clock as state.
REQ-031 A frame_tick outside SERVE, MISS and OVER SHALL not change the timer.

Reset
REQ-032 While reset_n=0 the block SHALL hold: state=IDLE, score=0x00, lives=0, timer=0, ball_enable=0, ball_reset=0, game_over=0, all edge registers=0.
REQ-033 Reset assertion SHALL take effect immediately, mid-game or mid-timer, without waiting for clk.
REQ-034 After reset_n rises, a start already held high SHALL not produce a start event until it goes low and high again.

Verification
REQ-035 Serve: reset, start pulse, 60 frame_ticks -> ball_reset high 1 clock on SERVE entry, state=2 and ball_enable=1 after tick 60, not after tick 59.
REQ-036 Scoring: in PLAY, hit held high 5 clocks -> score +1 only; 10 separate hit pulses from 0x00 -> 0x10; 120 pulses -> saturates at 0x99.
REQ-037 Lives: three miss pulses with LIVES=3 -> lives 2 (MISS), 1 (MISS), then 0 (OVER, game_over=1); IDLE after 180 ticks, score held until the next start event.
REQ-038 Simultaneous events: hit, miss and start in the same PLAY clock -> state=MISS, score unchanged, lives-1.
REQ-039 Pause: start event in PLAY -> state=3, ball_enable=0; hit and miss pulses ignored; second start event -> state=2.
REQ-040 Reset: reset_n low during MISS at timer=30 -> all outputs at reset values asynchronously; start held high through release -> remains IDLE.
